// File: rtl/spell_mem_router_if.sv
// spell_mem_router_if: Wishbone SRAM link between the router and OpenRAM.
// master drives cyc/stb/we/sel/addr/dat_o; slave returns dat_i/ack_i.
interface spell_mem_router_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [31:0]           sram_dat_i;
  logic                  sram_ack_i;
  logic                  sram_cyc_o;
  logic                  sram_stb_o;
  logic                  sram_we_o;
  logic [3:0]            sram_sel_o;
  logic [ADDR_WIDTH-1:0] sram_addr_o;
  logic [31:0]           sram_dat_o;

  modport master (
    input  sram_dat_i,
    input  sram_ack_i,
    output sram_cyc_o,
    output sram_stb_o,
    output sram_we_o,
    output sram_sel_o,
    output sram_addr_o,
    output sram_dat_o
  );

  modport slave (
    output sram_dat_i,
    output sram_ack_i,
    input  sram_cyc_o,
    input  sram_stb_o,
    input  sram_we_o,
    input  sram_sel_o,
    input  sram_addr_o,
    input  sram_dat_o
  );
endinterface

// File: rtl/spell_mem_router.sv
// spell_mem_router: routes spell CPU code/data accesses to IO, DFF or WB SRAM.
// Ports: clock/reset, CPU request (select..error), loc_* local blocks, wb master.
module spell_mem_router #(
  parameter int ADDR_WIDTH  = 8,
  parameter int IO_BASE     = 'h20,
  parameter int IO_LIMIT    = 'h60,
  parameter int WB_TIMEOUT  = 255,
  parameter int WORD_BUFFER = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sram_enable,
  input  logic                  select,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            data_in,
  input  logic                  memory_type_data,
  input  logic                  write,
  output logic [7:0]            data_out,
  output logic                  data_ready,
  output logic                  error,
  output logic                  loc_io_select,
  output logic                  loc_dff_select,
  output logic [ADDR_WIDTH-1:0] loc_addr,
  output logic [7:0]            loc_data,
  output logic                  loc_write,
  output logic                  loc_type_data,
  input  logic [7:0]            loc_data_in,
  input  logic                  loc_ready,
  spell_mem_router_if.master    wb
);
  localparam int AW = ADDR_WIDTH;
  localparam int TW = AW - 1;
  localparam logic [AW:0] IO_LO = (AW+1)'(IO_BASE);
  localparam logic [AW:0] IO_HI = (AW+1)'(IO_LIMIT);
  localparam logic [15:0] TO_LAST = 16'(WB_TIMEOUT - 1);
  localparam bit BUF_EN = (WORD_BUFFER != 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOCAL = 3'd1;
  localparam logic [2:0] S_BUS   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_REL   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [7:0]    wdat_q;
  logic          we_q;
  logic          type_q;
  logic          io_q;
  logic [7:0]    rdat_q;
  logic          err_q;
  logic [15:0]   cnt_q;
  logic [7:0]    dout_q;
  logic          rdy_q;
  logic          eout_q;
  logic [31:0]   buf_word_q;
  logic [TW-1:0] buf_tag_q;
  logic          buf_vld_q;

  logic          io_hit;
  logic          sram_tgt;
  logic          buf_hit;
  logic          bus_st;
  logic          tmo;
  logic [TW-1:0] live_tag;
  logic [TW-1:0] tag_q;
  logic [7:0]    buf_byte;
  logic [7:0]    ack_byte;

  always_comb begin
    io_hit   = memory_type_data &&
               ({1'b0, addr} >= IO_LO) &&
               ({1'b0, addr} < IO_HI);
    sram_tgt = !io_hit && sram_enable;
    live_tag = {memory_type_data, addr[AW-1:2]};
    tag_q    = {type_q, addr_q[AW-1:2]};
    buf_byte = buf_word_q[{addr[1:0], 3'b000} +: 8];
    ack_byte = wb.sram_dat_i[{addr_q[1:0], 3'b000} +: 8];
    buf_hit  = BUF_EN && sram_tgt && !write &&
               buf_vld_q && (buf_tag_q == live_tag);
    bus_st   = (state_q == S_BUS);
    tmo      = bus_st && !wb.sram_ack_i &&
               (cnt_q == TO_LAST);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (select) begin
          unique case (1'b1)
            !sram_tgt: state_d = S_LOCAL;
            buf_hit:   state_d = S_DONE;
            default:   state_d = S_BUS;
          endcase
        end
      end
      S_LOCAL: if (loc_ready) state_d = S_DONE;
      S_BUS: begin
        if (wb.sram_ack_i || tmo) state_d = S_DONE;
      end
      S_DONE:  state_d = S_REL;
      S_REL:   if (!select) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdat_q     <= '0;
      we_q       <= 1'b0;
      type_q     <= 1'b0;
      io_q       <= 1'b0;
      rdat_q     <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      dout_q     <= '0;
      rdy_q      <= 1'b0;
      eout_q     <= 1'b0;
      buf_word_q <= '0;
      buf_tag_q  <= '0;
      buf_vld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // outputs are registered off DONE, so they pulse in the cycle after it
      rdy_q   <= (state_q == S_DONE);
      eout_q  <= (state_q == S_DONE) && err_q;
      if (state_q == S_DONE) dout_q <= rdat_q;
      case (state_q)
        S_IDLE: begin
          if (select) begin
            addr_q <= addr;
            wdat_q <= data_in;
            we_q   <= write;
            type_q <= memory_type_data;
            io_q   <= io_hit;
            err_q  <= 1'b0;
            cnt_q  <= '0;
            if (buf_hit) rdat_q <= buf_byte;
          end
        end
        S_LOCAL: begin
          if (loc_ready) rdat_q <= loc_data_in;
        end
        S_BUS: begin
          if (wb.sram_ack_i) begin
            rdat_q <= ack_byte;
            if (BUF_EN && !we_q) begin
              buf_word_q <= wb.sram_dat_i;
              buf_tag_q  <= tag_q;
              buf_vld_q  <= 1'b1;
            end else if (BUF_EN && buf_vld_q &&
                         buf_tag_q == tag_q) begin
              // write-through: patch only the written lane
              buf_word_q[{addr_q[1:0], 3'b000} +: 8] <= wdat_q;
            end
          end else if (tmo) begin
            rdat_q <= 8'hFF;
            err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
      if (!sram_enable) buf_vld_q <= 1'b0;
    end
  end

  assign data_out       = dout_q;
  assign data_ready     = rdy_q;
  assign error          = eout_q;
  assign loc_io_select  = (state_q == S_LOCAL) && io_q;
  assign loc_dff_select = (state_q == S_LOCAL) && !io_q;
  assign loc_addr       = addr_q;
  assign loc_data       = wdat_q;
  assign loc_write      = we_q;
  assign loc_type_data  = type_q;

  assign wb.sram_cyc_o  = bus_st;
  assign wb.sram_stb_o  = bus_st;
  assign wb.sram_we_o   = bus_st && we_q;
  assign wb.sram_sel_o  = bus_st ? (4'b0001 << addr_q[1:0]) : 4'b0000;
  assign wb.sram_addr_o = bus_st ? {1'b0, tag_q} : '0;
  assign wb.sram_dat_o  = bus_st ? {4{wdat_q}} : 32'h0;
endmodule

// File: tb/tb_spell_mem_router.sv
// tb_spell_mem_router: scoreboard bench for spell_mem_router.
// WB and local responders on negedge; expected reads queued per access.
module tb_spell_mem_router;
  typedef struct packed {
    logic [7:0] d;
    logic       e;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       sram_enable;
  logic       select;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic       memory_type_data;
  logic       write;
  logic [7:0] data_out;
  logic       data_ready;
  logic       error;
  logic       loc_io_select;
  logic       loc_dff_select;
  logic [7:0] loc_addr;
  logic [7:0] loc_data;
  logic       loc_write;
  logic       loc_type_data;
  logic [7:0] loc_data_in;
  logic       loc_ready;

  spell_mem_router_if #(.ADDR_WIDTH(8)) wb ();

  spell_mem_router #(
    .ADDR_WIDTH (8),
    .IO_BASE    ('h20),
    .IO_LIMIT   ('h60),
    .WB_TIMEOUT (4),
    .WORD_BUFFER(1)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .sram_enable     (sram_enable),
    .select          (select),
    .addr            (addr),
    .data_in         (data_in),
    .memory_type_data(memory_type_data),
    .write           (write),
    .data_out        (data_out),
    .data_ready      (data_ready),
    .error           (error),
    .loc_io_select   (loc_io_select),
    .loc_dff_select  (loc_dff_select),
    .loc_addr        (loc_addr),
    .loc_data        (loc_data),
    .loc_write       (loc_write),
    .loc_type_data   (loc_type_data),
    .loc_data_in     (loc_data_in),
    .loc_ready       (loc_ready),
    .wb              (wb)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;
  exp_t sb_q[$];

  int ack_at;
  logic stray;
  logic [31:0] rdata;
  logic [7:0] lrdata;
  int cyc_run, cyc_tot, loc_run, io_tot, dff_tot;
  int rdy_tot = 0;
  logic [7:0] b_addr;
  logic [3:0] b_sel;
  logic b_we;
  logic [31:0] b_dat;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic e);
    mk.d = d;
    mk.e = e;
  endfunction

  initial begin
    wb.sram_ack_i = 1'b0;
    wb.sram_dat_i = '0;
    loc_ready = 1'b0;
    loc_data_in = '0;
    cyc_run = 0; cyc_tot = 0;
    loc_run = 0; io_tot = 0; dff_tot = 0;
    b_addr = '0; b_sel = '0; b_we = 1'b0; b_dat = '0;
    forever begin
      @(negedge clock);
      wb.sram_dat_i = rdata;
      loc_data_in = lrdata;
      if (wb.sram_cyc_o && wb.sram_stb_o) begin
        cyc_run++;
        cyc_tot++;
        if (cyc_run == 1) begin
          b_addr = wb.sram_addr_o;
          b_sel = wb.sram_sel_o;
          b_we = wb.sram_we_o;
          b_dat = wb.sram_dat_o;
        end
      end else begin
        cyc_run = 0;
      end
      wb.sram_ack_i = stray || (ack_at != 0 && cyc_run == ack_at);
      if (loc_io_select || loc_dff_select) begin
        loc_run++;
        if (loc_io_select) io_tot++;
        else dff_tot++;
      end else begin
        loc_run = 0;
      end
      loc_ready = stray || (loc_run == 2);
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (data_ready === 1'b1) begin
      rdy_tot++;
      if (sb_q.size() == 0) begin
        chk("rdy_extra", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("rdata", 32'(data_out), 32'(e.d));
        chk("error", 32'(error), 32'(e.e));
      end
    end else if (error === 1'b1) begin
      chk("err_no_rdy", 32'd1, 32'd0);
    end
  end

  task automatic xfer(input logic t, input logic [7:0] a,
                      input logic w, input logic [7:0] d,
                      input exp_t ex, output int lat);
    sb_q.push_back(ex);
    memory_type_data = t;
    addr = a;
    write = w;
    data_in = d;
    select = 1'b1;
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
    end while (data_ready !== 1'b1 && lat < 40);
    if (data_ready !== 1'b1) chk("rdy_timeout", 32'd0, 32'd1);
    select = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, c0, i0, d0, r0;
    logic [7:0] bnd_a [4];
    logic bnd_io [4];
    reset = 1'b1; select = 1'b0; sram_enable = 1'b1;
    addr = '0; data_in = '0; memory_type_data = 1'b0; write = 1'b0;
    ack_at = 1; stray = 1'b0; rdata = '0; lrdata = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_cyc", 32'(wb.sram_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb.sram_stb_o), 32'd0);
    chk("rst_rdy", 32'(data_ready), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    chk("rst_sel", 32'(wb.sram_sel_o), 32'd0);
    chk("rst_addr", 32'(wb.sram_addr_o), 32'd0);
    chk("rst_dat", wb.sram_dat_o, 32'd0);
    chk("rst_loc", 32'({loc_io_select, loc_dff_select}), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    rdata = 32'hDDCC_BBAA; ack_at = 2; c0 = cyc_tot;
    xfer(1'b1, 8'h05, 1'b0, 8'h00, mk(8'hBB, 1'b0), lat);
    chk("rd_addr", 32'(b_addr), 32'h41);
    chk("rd_sel", 32'(b_sel), 32'b0010);
    chk("rd_we", 32'(b_we), 32'd0);
    chk("rd_cyc", 32'(cyc_tot - c0), 32'd2);
    chk("rd_lat", 32'(lat), 32'd4);

    c0 = cyc_tot;
    xfer(1'b1, 8'h05, 1'b0, 8'h00, mk(8'hBB, 1'b0), lat);
    chk("hit_cyc", 32'(cyc_tot - c0), 32'd0);
    chk("hit_lat", 32'(lat), 32'd2);

    ack_at = 1; c0 = cyc_tot;
    xfer(1'b1, 8'h06, 1'b1, 8'h77, mk(8'hCC, 1'b0), lat);
    chk("wr_we", 32'(b_we), 32'd1);
    chk("wr_sel", 32'(b_sel), 32'b0100);
    chk("wr_dat", b_dat, 32'h7777_7777);
    chk("wr_addr", 32'(b_addr), 32'h41);
    chk("wr_lat", 32'(lat), 32'd3);

    c0 = cyc_tot;
    xfer(1'b1, 8'h06, 1'b0, 8'h00, mk(8'h77, 1'b0), lat);
    xfer(1'b1, 8'h07, 1'b0, 8'h00, mk(8'hDD, 1'b0), lat);
    chk("wt_hit_cyc", 32'(cyc_tot - c0), 32'd0);

    rdata = 32'h1122_3344; c0 = cyc_tot; i0 = io_tot;
    xfer(1'b0, 8'h30, 1'b0, 8'h00, mk(8'h44, 1'b0), lat);
    chk("code_addr", 32'(b_addr), 32'h0C);
    chk("code_cyc", 32'(cyc_tot - c0), 32'd1);
    chk("code_io", 32'(io_tot - i0), 32'd0);

    lrdata = 8'h5A; c0 = cyc_tot; i0 = io_tot;
    xfer(1'b1, 8'h30, 1'b0, 8'h00, mk(8'h5A, 1'b0), lat);
    chk("io_sel", 32'(io_tot - i0), 32'd2);
    chk("io_cyc", 32'(cyc_tot - c0), 32'd0);
    chk("io_laddr", 32'(loc_addr), 32'h30);
    chk("io_ltype", 32'(loc_type_data), 32'd1);
    chk("io_lwr", 32'(loc_write), 32'd0);

    ack_at = 0; c0 = cyc_tot;
    xfer(1'b1, 8'h08, 1'b0, 8'h00, mk(8'hFF, 1'b1), lat);
    chk("tmo_cyc", 32'(cyc_tot - c0), 32'd4);
    ack_at = 1; rdata = 32'h0102_0304; c0 = cyc_tot;
    xfer(1'b1, 8'h08, 1'b0, 8'h00, mk(8'h04, 1'b0), lat);
    chk("tmo_nofill", 32'(cyc_tot - c0), 32'd1);

    bnd_a[0] = 8'h1F; bnd_io[0] = 1'b0;
    bnd_a[1] = 8'h20; bnd_io[1] = 1'b1;
    bnd_a[2] = 8'h5F; bnd_io[2] = 1'b1;
    bnd_a[3] = 8'h60; bnd_io[3] = 1'b0;
    rdata = 32'hA5A5_A5A5;
    for (int k = 0; k < 4; k++) begin
      c0 = cyc_tot; i0 = io_tot;
      xfer(1'b1, bnd_a[k], 1'b0, 8'h00,
           mk(bnd_io[k] ? 8'h5A : 8'hA5, 1'b0), lat);
      chk("bnd_io", 32'(io_tot != i0), 32'(bnd_io[k]));
      chk("bnd_cyc", 32'(cyc_tot - c0), bnd_io[k] ? 32'd0 : 32'd1);
    end

    rdata = 32'hDDCC_BBAA;
    xfer(1'b1, 8'h05, 1'b0, 8'h00, mk(8'hBB, 1'b0), lat);
    sram_enable = 1'b0; lrdata = 8'h3C; c0 = cyc_tot; d0 = dff_tot;
    xfer(1'b1, 8'h05, 1'b0, 8'h00, mk(8'h3C, 1'b0), lat);
    chk("dff_sel", 32'(dff_tot - d0), 32'd2);
    chk("dff_cyc", 32'(cyc_tot - c0), 32'd0);
    sram_enable = 1'b1; c0 = cyc_tot;
    xfer(1'b1, 8'h05, 1'b0, 8'h00, mk(8'hBB, 1'b0), lat);
    chk("inval_cyc", 32'(cyc_tot - c0), 32'd1);

    ack_at = 0; r0 = rdy_tot;
    memory_type_data = 1'b1; addr = 8'h09; write = 1'b0; select = 1'b1;
    @(posedge clock); #1;
    chk("mid_cyc", 32'(wb.sram_cyc_o), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("mid_rst_cyc", 32'(wb.sram_cyc_o), 32'd0);
    chk("mid_rst_stb", 32'(wb.sram_stb_o), 32'd0);
    reset = 1'b0; select = 1'b0; stray = 1'b1;
    @(posedge clock); #1;
    stray = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
    end
    chk("mid_no_rdy", 32'(rdy_tot - r0), 32'd0);
    chk("mid_idle", 32'(wb.sram_cyc_o | loc_io_select), 32'd0);
    chk("mid_dout", 32'(data_out), 32'd0);

    lrdata = 8'h99; r0 = rdy_tot; i0 = io_tot; lat = 0;
    sb_q.push_back(mk(8'h99, 1'b0));
    memory_type_data = 1'b1; addr = 8'h40; write = 1'b0; select = 1'b1;
    do begin
      @(posedge clock); #1;
      lat++;
    end while (data_ready !== 1'b1 && lat < 40);
    if (data_ready !== 1'b1) chk("hold_timeout", 32'd0, 32'd1);
    repeat (5) begin
      @(posedge clock); #1;
    end
    chk("hold_rdy", 32'(rdy_tot - r0), 32'd1);
    chk("hold_io", 32'(io_tot - i0), 32'd2);
    select = 1'b0;
    repeat (2) begin
      @(posedge clock); #1;
    end
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spell_mem_router.md
Name: spell_mem_router

Overview:
- Parametrised successor to the spell memory front-end.
- Decodes each CPU access (code/data) to one of three targets: IO window, local DFF memory, or Wishbone SRAM.
- Adds what the previous block lacked: a registered transaction FSM, a Wishbone timeout with error reporting, and an optional one-word read buffer (write-through).
- Sits between the spell CPU core and the IO, DFF and OpenRAM Wishbone blocks.

Parameters:
- ADDR_WIDTH, 8, CPU byte-address width (≥4).
- IO_BASE, 'h20, first data address routed to IO.
- IO_LIMIT, 'h60, first data address past the IO window (exclusive).
- WB_TIMEOUT, 255, bus cycles to wait for ack before erroring (1..65535).
- WORD_BUFFER, 1, 1 = enable the one-word read buffer; 0 = every SRAM read goes to the bus.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sram_enable  in  1  1 = memory targets use Wishbone SRAM; 0 = use local DFF.
- select  in  1  CPU request; held high until data_ready, then dropped.
- addr  in  ADDR_WIDTH  CPU byte address.
- data_in  in  8  write data.
- memory_type_data  in  1  1 = data space, 0 = code space.
- write  in  1  1 = write, 0 = read.
- data_out  out  8  read data; valid while data_ready=1.
- data_ready  out  1  one-cycle completion pulse.
- error  out  1  high together with data_ready when a bus timeout occurred.
- loc_io_select  out  1  request to the IO block.
- loc_dff_select  out  1  request to the DFF block.
- loc_addr  out  ADDR_WIDTH  latched address.
- loc_data  out  8  latched write data.
- loc_write  out  1  latched write flag.
- loc_type_data  out  1  latched memory type.
- loc_data_in  in  8  read data from the selected local block.
- loc_ready  in  1  completion from the selected local block.
- sram_dat_i  in  32  Wishbone read data.
- sram_ack_i  in  1  Wishbone acknowledge.
- sram_cyc_o  out  1  Wishbone cycle.
- sram_stb_o  out  1  Wishbone strobe.
- sram_we_o  out  1  Wishbone write enable.
- sram_sel_o  out  4  Wishbone byte select.
- sram_addr_o  out  ADDR_WIDTH  Wishbone word address.
- sram_dat_o  out  32  Wishbone write data.

Behaviour:
- Decode, evaluated on the inputs in IDLE:
  - io = memory_type_data && IO_BASE≤addr<IO_LIMIT.
  - mem = not io.
  - SRAM target = mem && sram_enable; DFF target = mem && !sram_enable.
- Request registers:
  - In IDLE, when select=1, latch addr, data_in, write, memory_type_data and target.
  - All outputs are driven from the latched values, never from the live inputs.
- FSM states: IDLE, LOCAL, BUS, DONE, RELEASE.
- IDLE transitions on select=1:
  - IO or DFF target → LOCAL.
  - SRAM read hitting the buffer (WORD_BUFFER=1) → DONE.
  - Any other SRAM access → BUS.
- LOCAL:
  - loc_io_select or loc_dff_select high.
  - On loc_ready, capture loc_data_in → DONE.
- BUS:
  - sram_cyc_o = sram_stb_o = 1.
  - sram_we_o = latched write.
  - sram_sel_o = 1<<addr[1:0].
  - sram_addr_o = {type_data, addr[ADDR_WIDTH-1:2]}, zero-extended to ADDR_WIDTH.
  - sram_dat_o = latched data replicated ×4.
  - On sram_ack_i: capture the selected byte lane of sram_dat_i → DONE, and drop cyc/stb the next cycle.
  - Timeout counter runs from 0 and increments each BUS cycle. If it reaches WB_TIMEOUT without ack → DONE with error=1, data_out=8'hFF.
- DONE: data_ready=1 for exactly one cycle; error valid in the same cycle → RELEASE.
- RELEASE: wait for select=0 → IDLE. A still-high select is never re-issued.
- Latency, counted from the cycle select is first seen in IDLE:
  - Buffer hit: data_ready 2 edges later.
  - Bus access with ack in the first BUS cycle: data_ready 3 edges later.
- Word buffer:
  - Contents: 32-bit word, tag {type_data, addr[ADDR_WIDTH-1:2]}, valid bit.
  - Filled on every acked SRAM read.
  - An acked SRAM write whose tag matches updates only the written byte (write-through); a mismatching write leaves the buffer unchanged.
  - A timeout never fills or updates the buffer.
  - sram_enable=0 invalidates it.
- Idle output values: when not in BUS, cyc, stb, we = 0. When not in LOCAL, loc_*_select = 0.
- Reset values:
  - All strobes, data_ready and error = 0; data_out = 0; sram_sel_o = 0; sram_addr_o = 0; sram_dat_o = 0.
  - Buffer invalid; FSM in IDLE; timeout counter = 0.
- Reset mid-transaction: cyc/stb drop at the reset edge, no data_ready is produced, and a late ack is ignored in IDLE.
- Stray ack or loc_ready outside BUS/LOCAL is ignored.

Test Plan:
- Data read addr 'h05, sram_enable=1, sram_dat_i='hDDCCBBAA acked after 2 cycles → sram_addr_o='h41, sel=4'b0010, data_out='hBB, one-cycle data_ready, error=0.
- Repeat the same read with WORD_BUFFER=1 → no cyc, data_ready 2 edges after select. Then write 'h77 to 'h06 (acked), then read 'h06 → data_out='h77 with no bus cycle.
- Code read addr 'h30 → SRAM path (not IO), sram_addr_o='h0C. Data read addr 'h30 → loc_io_select=1; loc_data_in='h5A with loc_ready → data_out='h5A.
- WB_TIMEOUT=4, no ack → cyc high for 4 cycles, then data_ready=1, error=1, data_out='hFF; a later read of the same address still goes to the bus.
- Reset asserted while in BUS → cyc/stb=0 next edge, no data_ready; an ack the following cycle is ignored.
- select held high for 5 cycles after data_ready → exactly one transaction and one data_ready pulse.
